// File: rtl/branch_unit_if.sv
// Decision/backtrack bus between the branch unit and the solver controlling it.
// The master side configures the order table, reports assignments, requests
// and accepts decisions, and issues backtracks; the slave side is the unit.
interface branch_unit_if #(
  parameter int NUM_VARS = 64
);
  localparam int VAR_BITS = $clog2(NUM_VARS);
  localparam int LVL_BITS = $clog2(NUM_VARS + 1);

  logic                cfg_we;
  logic [VAR_BITS-1:0] cfg_addr;
  logic [VAR_BITS-1:0] cfg_var;
  logic                cfg_pol;
  logic [NUM_VARS-1:0] assigned;
  logic                req;
  logic                dec_valid;
  logic                dec_ready;
  logic [VAR_BITS-1:0] dec_var;
  logic                dec_pol;
  logic [LVL_BITS-1:0] dec_level;
  logic                bt_valid;
  logic [LVL_BITS-1:0] bt_level;
  logic                bt_err;
  logic                done;
  logic [LVL_BITS-1:0] cur_level;

  modport master (
    output cfg_we, cfg_addr, cfg_var, cfg_pol, assigned, req, dec_ready,
           bt_valid, bt_level,
    input  dec_valid, dec_var, dec_pol, dec_level, bt_err, done, cur_level
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_var, cfg_pol, assigned, req, dec_ready,
           bt_valid, bt_level,
    output dec_valid, dec_var, dec_pol, dec_level, bt_err, done, cur_level
  );
endinterface

// File: rtl/branch_unit.sv
// Branch unit: walks a configurable decision-order table, presents the next
// unassigned variable as a decision, tracks the committed decision level and
// remembers where each level's decision was found so a backtrack can resume
// the scan from that point. Polarity always comes from the table.
module branch_unit #(
  parameter int NUM_VARS = 64
) (
  input logic         clock,
  input logic         reset,
  branch_unit_if.slave bus
);
  localparam int VAR_BITS = $clog2(NUM_VARS);
  localparam int LVL_BITS = $clog2(NUM_VARS + 1);
  localparam logic [LVL_BITS-1:0] END_PTR = LVL_BITS'(NUM_VARS);
  localparam logic [LVL_BITS-1:0] ONE     = LVL_BITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PRESENT,
    DONE
  } state_t;

  state_t              state;
  logic [VAR_BITS-1:0] tbl_var [NUM_VARS];
  logic [NUM_VARS-1:0] tbl_pol;
  logic [LVL_BITS-1:0] ptr;
  logic [LVL_BITS-1:0] lvl;
  logic [LVL_BITS-1:0] pos [NUM_VARS+1];
  logic [VAR_BITS-1:0] dec_var_q;
  logic                dec_pol_q;
  logic [LVL_BITS-1:0] dec_level_q;
  logic                bt_err_q;

  logic [VAR_BITS-1:0] scan_idx;
  logic [VAR_BITS-1:0] scan_var;
  logic                scan_assigned;
  logic                bt_ok;
  logic [LVL_BITS-1:0] bt_slot;
  logic [LVL_BITS-1:0] lvl_next;

  // Only meaningful while ptr < NUM_VARS; the end case is tested first.
  assign scan_idx      = ptr[VAR_BITS-1:0];
  assign scan_var      = tbl_var[scan_idx];
  assign scan_assigned = bus.assigned[scan_var];
  assign bt_ok         = bus.bt_level < lvl;
  assign bt_slot       = bus.bt_level + ONE;
  assign lvl_next      = lvl + ONE;

  // Single sequential process: reset, then backtrack, then handshakes, then config.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      lvl         <= '0;
      dec_var_q   <= '0;
      dec_pol_q   <= 1'b0;
      dec_level_q <= '0;
      bt_err_q    <= 1'b0;
      tbl_pol     <= '0;
      for (int i = 0; i < NUM_VARS; i++) begin
        tbl_var[i] <= VAR_BITS'(i);
      end
      for (int i = 0; i <= NUM_VARS; i++) begin
        pos[i] <= '0;
      end
    end else if (bus.bt_valid) begin
      // Any backtrack request blocks the other events this cycle; a rejected
      // one only raises the error pulse.
      bt_err_q <= !bt_ok;
      if (bt_ok) begin
        lvl   <= bus.bt_level;
        ptr   <= pos[bt_slot];
        state <= IDLE;
      end
    end else begin
      bt_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            state <= SCAN;
          end else if (bus.cfg_we) begin
            tbl_var[bus.cfg_addr] <= bus.cfg_var;
            tbl_pol[bus.cfg_addr] <= bus.cfg_pol;
          end
        end
        SCAN: begin
          if (ptr == END_PTR) begin
            state <= DONE;
          end else if (scan_assigned) begin
            ptr <= ptr + ONE;
          end else begin
            dec_var_q   <= scan_var;
            dec_pol_q   <= tbl_pol[scan_idx];
            dec_level_q <= lvl_next;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.dec_ready) begin
            lvl           <= lvl_next;
            pos[lvl_next] <= ptr;
            ptr           <= ptr + ONE;
            state         <= IDLE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.dec_valid = (state == PRESENT);
  assign bus.done      = (state == DONE);
  assign bus.dec_var   = dec_var_q;
  assign bus.dec_pol   = dec_pol_q;
  assign bus.dec_level = dec_level_q;
  assign bus.bt_err    = bt_err_q;
  assign bus.cur_level = lvl;
endmodule

// File: tb/tb_branch_unit.sv
// Testbench for branch_unit with NUM_VARS=8: directed scenarios with literal
// expectations plus a transaction-level model compared on every cycle.
module tb_branch_unit;
  localparam int N = 8;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  branch_unit_if #(.NUM_VARS(N)) bus ();

  branch_unit #(.NUM_VARS(N)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_WAIT, M_PRESENT, M_DONE} mphase_t;

  mphase_t phase;
  int      m_lvl;
  int      m_ptr;
  int      m_pos [N+1];
  int      m_tbl_var [N];
  bit      m_tbl_pol [N];
  int      m_remaining;
  bit      m_target_done;
  int      m_dec_var;
  bit      m_dec_pol;
  int      m_dec_level;
  bit      m_bterr;
  bit      model_live;
  int      m_k;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Model: a req finds the first unassigned entry k places ahead and the
  // outcome shows up 1+k edges later; everything else is level bookkeeping.
  always @(posedge clock) begin
    if (reset) begin
      m_lvl = 0;
      m_ptr = 0;
      for (int i = 0; i <= N; i++) m_pos[i] = 0;
      for (int i = 0; i < N; i++) begin
        m_tbl_var[i] = i;
        m_tbl_pol[i] = 1'b0;
      end
      m_dec_var   = 0;
      m_dec_pol   = 1'b0;
      m_dec_level = 0;
      m_bterr     = 1'b0;
      phase       = M_IDLE;
      model_live  = 1'b1;
    end else if (model_live) begin
      m_bterr = 1'b0;
      if (bus.bt_valid) begin
        if (int'(bus.bt_level) < m_lvl) begin
          m_lvl = int'(bus.bt_level);
          m_ptr = m_pos[m_lvl + 1];
          phase = M_IDLE;
        end else begin
          m_bterr = 1'b1;
        end
      end else begin
        case (phase)
          M_IDLE: begin
            if (bus.req) begin
              m_k = 0;
              while ((m_ptr + m_k < N) && bus.assigned[m_tbl_var[m_ptr + m_k]]) m_k++;
              m_target_done = (m_ptr + m_k == N);
              m_ptr         = m_ptr + m_k;
              m_remaining   = 1 + m_k;
              phase         = M_WAIT;
            end else if (bus.cfg_we) begin
              m_tbl_var[bus.cfg_addr] = int'(bus.cfg_var);
              m_tbl_pol[bus.cfg_addr] = bus.cfg_pol;
            end
          end
          M_WAIT: begin
            m_remaining--;
            if (m_remaining == 0) begin
              if (m_target_done) begin
                phase = M_DONE;
              end else begin
                m_dec_var   = m_tbl_var[m_ptr];
                m_dec_pol   = m_tbl_pol[m_ptr];
                m_dec_level = m_lvl + 1;
                phase       = M_PRESENT;
              end
            end
          end
          M_PRESENT: begin
            if (bus.dec_ready) begin
              m_lvl        = m_lvl + 1;
              m_pos[m_lvl] = m_ptr;
              m_ptr        = m_ptr + 1;
              phase        = M_IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (model_live) begin
      checkOutput("cmp_dec_valid", 32'(bus.dec_valid), 32'(phase == M_PRESENT));
      checkOutput("cmp_done", 32'(bus.done), 32'(phase == M_DONE));
      checkOutput("cmp_cur_level", 32'(bus.cur_level), m_lvl);
      checkOutput("cmp_bt_err", 32'(bus.bt_err), 32'(m_bterr));
      checkOutput("cmp_dec_var", 32'(bus.dec_var), m_dec_var);
      checkOutput("cmp_dec_pol", 32'(bus.dec_pol), 32'(m_dec_pol));
      checkOutput("cmp_dec_level", 32'(bus.dec_level), m_dec_level);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic r, input logic rdy, input logic btv,
                               input logic [3:0] btl);
    bus.req       = r;
    bus.dec_ready = rdy;
    bus.bt_valid  = btv;
    bus.bt_level  = btl;
    @(posedge clock);
    #1;
    bus.req       = 1'b0;
    bus.dec_ready = 1'b0;
    bus.bt_valid  = 1'b0;
    bus.bt_level  = '0;
  endtask

  task automatic writeEntry(input int addr, input int v, input logic p);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(addr);
    bus.cfg_var  = 3'(v);
    bus.cfg_pol  = p;
    @(posedge clock);
    #1;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Called right after a req edge; d is the offset from the req cycle.
  task automatic waitFor(input bit want_done, input string name, output int d);
    d = 1;
    @(negedge clock);
    while (!(want_done ? bus.done : bus.dec_valid) && d < 40) begin
      @(negedge clock);
      d++;
    end
    if (!(want_done ? bus.done : bus.dec_valid))
      checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic expectDecision(input string name, input int lat, input int v,
                                input logic p, input int level);
    int d;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    waitFor(1'b0, name, d);
    checkOutput({name, "_latency"}, d, lat);
    checkOutput({name, "_var"}, 32'(bus.dec_var), v);
    checkOutput({name, "_pol"}, 32'(bus.dec_pol), 32'(p));
    checkOutput({name, "_level"}, 32'(bus.dec_level), level);
  endtask

  task automatic acceptDecision(input string name, input int new_level);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clock);
    checkOutput({name, "_valid_drop"}, 32'(bus.dec_valid), 32'd0);
    checkOutput({name, "_cur_level"}, 32'(bus.cur_level), new_level);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int d;
    tests      = 0;
    fails      = 0;
    model_live = 1'b0;
    reset      = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_var = '0; bus.cfg_pol = 1'b0;
    bus.assigned = '0; bus.req = 1'b0; bus.dec_ready = 1'b0;
    bus.bt_valid = 1'b0; bus.bt_level = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clock);
    checkOutput("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_cur_level", 32'(bus.cur_level), 32'd0);
    checkOutput("rst_bt_err", 32'(bus.bt_err), 32'd0);
    checkOutput("rst_dec_var", 32'(bus.dec_var), 32'd0);
    checkOutput("rst_dec_level", 32'(bus.dec_level), 32'd0);

    // Identity order, nothing assigned: vars 0,1,2 at levels 1,2,3
    expectDecision("first", 2, 0, 1'b0, 1);
    acceptDecision("first_acc", 1);
    bus.assigned[0] = 1'b1;
    expectDecision("second", 2, 1, 1'b0, 2);
    acceptDecision("second_acc", 2);
    bus.assigned[1] = 1'b1;
    expectDecision("third", 2, 2, 1'b0, 3);
    acceptDecision("third_acc", 3);
    bus.assigned[2] = 1'b1;

    // Backtrack to the current level is rejected
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd3);
    @(negedge clock);
    checkOutput("bt_same_err", 32'(bus.bt_err), 32'd1);
    checkOutput("bt_same_level", 32'(bus.cur_level), 32'd3);

    // Backtrack to level 1 and resume at var 1
    bus.assigned = 8'b0000_0001;
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
    @(negedge clock);
    checkOutput("bt1_level", 32'(bus.cur_level), 32'd1);
    checkOutput("bt1_err", 32'(bus.bt_err), 32'd0);
    expectDecision("resume", 2, 1, 1'b0, 2);
    acceptDecision("resume_acc", 2);
    bus.assigned = 8'b0000_0011;

    // Backtrack coinciding with dec_ready cancels the commit
    expectDecision("pre_cancel", 2, 2, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
    @(negedge clock);
    checkOutput("cancel_level", 32'(bus.cur_level), 32'd0);
    checkOutput("cancel_valid", 32'(bus.dec_valid), 32'd0);
    bus.assigned = '0;
    expectDecision("after_cancel", 2, 0, 1'b0, 1);

    // Reset while presenting aborts without commit
    pulseReset();
    @(negedge clock);
    checkOutput("rst_present_level", 32'(bus.cur_level), 32'd0);
    checkOutput("rst_present_valid", 32'(bus.dec_valid), 32'd0);

    // Three assigned entries skipped: latency 5
    bus.assigned = 8'b0000_0111;
    expectDecision("skip3", 5, 3, 1'b0, 1);

    // Reset in the middle of a scan
    pulseReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    pulseReset();
    repeat (6) begin
      @(negedge clock);
      checkOutput("rst_scan_valid", 32'(bus.dec_valid), 32'd0);
    end
    expectDecision("skip3_again", 5, 3, 1'b0, 1);

    // Reversed order table with polarity 1
    pulseReset();
    bus.assigned = '0;
    for (int i = 0; i < N; i++) writeEntry(i, 7 - i, 1'b1);
    expectDecision("rev0", 2, 7, 1'b1, 1);
    acceptDecision("rev0_acc", 1);
    expectDecision("rev1", 2, 6, 1'b1, 2);
    acceptDecision("rev1_acc", 2);
    expectDecision("rev2", 2, 5, 1'b1, 3);
    writeEntry(3, 0, 1'b0);
    checkOutput("cfg_in_present_valid", 32'(bus.dec_valid), 32'd1);
    acceptDecision("rev2_acc", 3);
    expectDecision("rev3", 2, 4, 1'b1, 4);

    // Reset restores identity order
    pulseReset();
    expectDecision("identity", 2, 0, 1'b0, 1);

    // Everything assigned: done after 10 cycles, sticky, bad backtrack rejected
    pulseReset();
    bus.assigned = 8'hFF;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    waitFor(1'b1, "done", d);
    checkOutput("done_latency", d, 32'd10);
    repeat (4) begin
      @(negedge clock);
      checkOutput("done_sticky", 32'(bus.done), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    @(negedge clock);
    checkOutput("done_bt_err", 32'(bus.bt_err), 32'd1);
    checkOutput("done_bt_done", 32'(bus.done), 32'd1);
    @(negedge clock);
    checkOutput("done_bt_err_pulse", 32'(bus.bt_err), 32'd0);
    checkOutput("done_still", 32'(bus.done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
